traffic_gen_cpu: RTL



---
 rtl/traffic_gen_cpu_if.sv | 16 +
 rtl/traffic_gen_cpu.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/traffic_gen_cpu_if.sv
// Purpose : CPU-side register port of one nic (register select, write data, read data, strobes).
// Latency : reads return d_in on the cycle after the nicEn request; writes take effect in the strobe cycle.
// Backpres: none on the port itself; the nic reports full buffers through its status registers.
// Ports   : addr/d_out/nicEn/nicEnWR driven by the master (traffic generator), d_in driven by the slave (nic).
interface traffic_gen_cpu_if #(
   parameter int PACKET_WIDTH = 64
);
   logic [1:0]              addr;
   logic [PACKET_WIDTH-1:0] d_out;
   logic [PACKET_WIDTH-1:0] d_in;
   logic                    nicEn;
   logic                    nicEnWR;

   modport master (output addr, output d_out, output nicEn, output nicEnWR, input d_in);
   modport slave  (input addr, input d_out, input nicEn, input nicEnWR, output d_in);
endinterface

// File: rtl/traffic_gen_cpu.sv
// Purpose : traffic generating PE in front of one nic; injects NUM_PKTS addressed packets round-robin and drains/counts received ones.
// Latency : reads are request + capture (2 cycles); a send-only poll loop is 7 cycles, writes spaced by INJ_GAP idle cycles.
// Backpres: writes wait while the nic output status reports full; receive polling is never blocked by enable, done or the gap.
// Ports   : clk, reset (sync, active-high), enable, router_position {row,col}, polarity (vc bit),
//           nic (register port, master side), tx_count/rx_count (saturating), done, err (sticky).
// Option  : define TRAFFIC_GEN_CHECK_EN to check header fields and per-source sequence order of received packets.
module traffic_gen_cpu #(
   parameter int PACKET_WIDTH = 64,
   parameter int SIZE_X       = 4,
   parameter int SIZE_Y       = 4,
   parameter int NUM_PKTS     = 16,
   parameter int INJ_GAP      = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     enable,
   input  logic [3:0]               router_position,
   input  logic                     polarity,
   traffic_gen_cpu_if.master        nic,
   output logic [15:0]              tx_count,
   output logic [15:0]              rx_count,
   output logic                     done,
   output logic                     err
);

   localparam int          NUM_NODES    = SIZE_X * SIZE_Y;
   localparam logic [15:0] NUM_PKTS_C   = 16'(NUM_PKTS);
   localparam logic [15:0] GAP_LOAD     = 16'(INJ_GAP);
   localparam logic [15:0] CNT_MAX      = 16'hFFFF;
   localparam logic [1:0]  ADDR_IN_DAT  = 2'd0;
   localparam logic [1:0]  ADDR_IN_ST   = 2'd1;
   localparam logic [1:0]  ADDR_OUT_DAT = 2'd2;
   localparam logic [1:0]  ADDR_OUT_ST  = 2'd3;

   typedef enum logic [3:0] {
      IDLE, RD_IN_ST, CAP_IN_ST, RD_IN, CAP_IN, RD_OUT_ST, CAP_OUT_ST, WR_OUT, GAP
   } state_t;

   state_t                  state, state_nxt;
   logic [15:0]             gap_cnt;
   logic [3:0]              dest_idx;
   logic [3:0]              own_idx;
   logic                    tx_ok;
   logic [PACKET_WIDTH-1:0] tx_pkt;

   // Linear node index of a {row,col} position.
   function automatic logic [3:0] node_idx(input logic [3:0] pos);
      int i;
      i = int'(pos[3:2]) * SIZE_Y + int'(pos[1:0]);
      return 4'(i);
   endfunction

   // Back from a linear index to the {row,col} encoding used on the wire.
   function automatic logic [3:0] idx_to_pos(input logic [3:0] idx);
      int r;
      int c;
      r = int'(idx) / SIZE_Y;
      c = int'(idx) % SIZE_Y;
      return {r[1:0], c[1:0]};
   endfunction

   // Next destination: increment with wrap, stepping over our own node.
   function automatic logic [3:0] next_idx(input logic [3:0] cur, input logic [3:0] own);
      int n;
      n = int'(cur) + 1;
      if (n >= NUM_NODES) n = 0;
      if (n == int'(own)) begin
         n = n + 1;
         if (n >= NUM_NODES) n = 0;
      end
      return 4'(n);
   endfunction

   assign own_idx = node_idx(router_position);
   assign done    = (tx_count == NUM_PKTS_C);

   // Sequence is written first so the header fields win if a narrow packet overlaps them.
   always_comb begin
      tx_pkt                         = '0;
      tx_pkt[31:0]                   = {16'h0000, tx_count};
      tx_pkt[PACKET_WIDTH-17 -: 4]   = idx_to_pos(dest_idx);
      tx_pkt[PACKET_WIDTH-21 -: 4]   = router_position;
      tx_pkt[PACKET_WIDTH-1]         = polarity;
   end

   // Next state and nic strobes; all outputs are decoded from the current state only.
   always_comb begin
      state_nxt   = state;
      nic.addr    = 2'd0;
      nic.d_out   = '0;
      nic.nicEn   = 1'b0;
      nic.nicEnWR = 1'b0;
      tx_ok       = enable && !done && (gap_cnt == 16'd0);
      case (state)
         IDLE:       state_nxt = RD_IN_ST;
         RD_IN_ST: begin
            nic.nicEn = 1'b1;
            nic.addr  = ADDR_IN_ST;
            state_nxt = CAP_IN_ST;
         end
         CAP_IN_ST: begin
            if (nic.d_in[0])  state_nxt = RD_IN;
            else if (tx_ok)   state_nxt = RD_OUT_ST;
            else              state_nxt = IDLE;
         end
         RD_IN: begin
            nic.nicEn = 1'b1;
            nic.addr  = ADDR_IN_DAT;
            state_nxt = CAP_IN;
         end
         CAP_IN:     state_nxt = tx_ok ? RD_OUT_ST : IDLE;
         RD_OUT_ST: begin
            nic.nicEn = 1'b1;
            nic.addr  = ADDR_OUT_ST;
            state_nxt = CAP_OUT_ST;
         end
         // Once the output buffer has room the write goes ahead even if enable dropped meanwhile.
         CAP_OUT_ST: state_nxt = nic.d_in[0] ? IDLE : WR_OUT;
         WR_OUT: begin
            nic.nicEn   = 1'b1;
            nic.nicEnWR = 1'b1;
            nic.addr    = ADDR_OUT_DAT;
            nic.d_out   = tx_pkt;
            state_nxt   = GAP;
         end
         GAP:        state_nxt = IDLE;
         default:    state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         tx_count <= 16'd0;
         rx_count <= 16'd0;
         gap_cnt  <= 16'd0;
         dest_idx <= next_idx(own_idx, own_idx);
      end else begin
         state <= state_nxt;
         // Gap counter runs down in every state so it only throttles injection, never polling.
         if (state == WR_OUT) begin
            gap_cnt  <= GAP_LOAD;
            dest_idx <= next_idx(dest_idx, own_idx);
            if (tx_count != CNT_MAX) tx_count <= tx_count + 16'd1;
         end else if (gap_cnt != 16'd0) begin
            gap_cnt <= gap_cnt - 16'd1;
         end
         if (state == CAP_IN && rx_count != CNT_MAX) rx_count <= rx_count + 16'd1;
      end
   end

`ifdef TRAFFIC_GEN_CHECK_EN
   logic [3:0]  rx_dest;
   logic [3:0]  rx_src;
   logic [14:0] rx_pad;
   logic [31:0] rx_seq;
   logic        rx_hdr_bad;
   logic [31:0] exp_seq [16];
   logic        unused_rx;

   assign rx_dest    = nic.d_in[PACKET_WIDTH-17 -: 4];
   assign rx_src     = nic.d_in[PACKET_WIDTH-21 -: 4];
   assign rx_pad     = nic.d_in[PACKET_WIDTH-2 -: 15];
   assign rx_seq     = nic.d_in[31:0];
   assign rx_hdr_bad = (rx_dest != router_position) || (rx_src == router_position) || (rx_pad != 15'd0);
   assign unused_rx  = ^{nic.d_in[PACKET_WIDTH-1], nic.d_in[PACKET_WIDTH-25:32]};

   // Each source is expected to count up from 0 without gaps or repeats.
   always_ff @(posedge clk) begin
      if (reset) begin
         err <= 1'b0;
         for (int i = 0; i < 16; i++) exp_seq[i] <= 32'd0;
      end else if (state == CAP_IN) begin
         if (rx_hdr_bad || (rx_seq != exp_seq[rx_src])) err <= 1'b1;
         exp_seq[rx_src] <= rx_seq + 32'd1;
      end
   end
`else
   logic unused_rx;

   assign unused_rx = ^nic.d_in[PACKET_WIDTH-1:1];
   assign err       = 1'b0;
`endif

endmodule
